// File: rtl/pb_repeat_ctrl.sv
// Push-button conditioner for the RTC time-set path: synchronise, debounce on a
// millisecond tick, then emit one increment pulse on press plus auto-repeat while held.
module pb_repeat_ctrl #(
    parameter int unsigned TICK_DIV = 49999,
    parameter int unsigned DEB_MS   = 10,
    parameter int unsigned HOLD_MS  = 500,
    parameter int unsigned RPT_MS   = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] push_but,
    input  logic       man_sw,
    output logic [2:0] pben,
    output logic [2:0] pressed
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT,
        ST_LOCK
    } state_t;

    localparam logic [15:0] TICK_END = 16'(TICK_DIV);
    localparam logic [15:0] DEB_END  = 16'(DEB_MS - 1);
    localparam logic [15:0] HOLD_END = 16'(HOLD_MS - 1);
    localparam logic [15:0] RPT_END  = 16'(RPT_MS - 1);

    logic [15:0] r_tick_cnt;
    logic        w_tick;
    logic [2:0]  r_sync1;
    logic [2:0]  r_sync2;
    logic [2:0]  r_pressed;
    logic [15:0] r_deb_cnt [3];
    logic [2:0]  w_rel;
    state_t      r_state [3];
    state_t      w_state_nxt [3];
    logic [15:0] r_rpt_cnt [3];
    logic [15:0] w_rpt_nxt [3];
    logic [2:0]  r_pben;
    logic [2:0]  w_pben_nxt;

    assign w_tick = (r_tick_cnt == TICK_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 16'd1;
        end
    end

    // Inverted so that 1 means pressed from here on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= ~push_but;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pressed <= '0;
            for (int i = 0; i < 3; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else if (w_tick) begin
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] != r_pressed[i]) begin
                    if (r_deb_cnt[i] == DEB_END) begin
                        r_pressed[i] <= r_sync2[i];
                        r_deb_cnt[i] <= '0;
                    end else begin
                        r_deb_cnt[i] <= r_deb_cnt[i] + 16'd1;
                    end
                end else begin
                    r_deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Release accepted on this tick: lets the FSM drop a coinciding repeat pulse.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_rel[i] = w_tick && r_pressed[i] && !r_sync2[i] && (r_deb_cnt[i] == DEB_END);
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_state_nxt[i] = r_state[i];
            w_rpt_nxt[i]   = r_rpt_cnt[i];
            w_pben_nxt[i]  = 1'b0;
            if (!r_pressed[i]) begin
                w_state_nxt[i] = ST_IDLE;
                w_rpt_nxt[i]   = '0;
            end else begin
                case (r_state[i])
                    ST_IDLE: begin
                        w_rpt_nxt[i] = '0;
                        if (man_sw) begin
                            w_pben_nxt[i]  = 1'b1;
                            w_state_nxt[i] = ST_HOLD;
                        end else begin
                            w_state_nxt[i] = ST_LOCK;
                        end
                    end
                    ST_HOLD: begin
                        if (!man_sw) begin
                            w_state_nxt[i] = ST_LOCK;
                            w_rpt_nxt[i]   = '0;
                        end else if (w_tick) begin
                            if (r_rpt_cnt[i] == HOLD_END) begin
                                w_pben_nxt[i]  = !w_rel[i];
                                w_rpt_nxt[i]   = '0;
                                w_state_nxt[i] = ST_REPEAT;
                            end else begin
                                w_rpt_nxt[i] = r_rpt_cnt[i] + 16'd1;
                            end
                        end
                    end
                    ST_REPEAT: begin
                        if (!man_sw) begin
                            w_state_nxt[i] = ST_LOCK;
                            w_rpt_nxt[i]   = '0;
                        end else if (w_tick) begin
                            if (r_rpt_cnt[i] == RPT_END) begin
                                w_pben_nxt[i] = !w_rel[i];
                                w_rpt_nxt[i]  = '0;
                            end else begin
                                w_rpt_nxt[i] = r_rpt_cnt[i] + 16'd1;
                            end
                        end
                    end
                    default: begin
                        w_state_nxt[i] = ST_LOCK;
                        w_rpt_nxt[i]   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pben <= '0;
            for (int i = 0; i < 3; i++) begin
                r_state[i]   <= ST_IDLE;
                r_rpt_cnt[i] <= '0;
            end
        end else begin
            r_pben <= w_pben_nxt;
            for (int i = 0; i < 3; i++) begin
                r_state[i]   <= w_state_nxt[i];
                r_rpt_cnt[i] <= w_rpt_nxt[i];
            end
        end
    end

    assign pben    = r_pben;
    assign pressed = r_pressed;

endmodule

// File: tb/tb_pb_repeat_ctrl.sv
// Directed bench for pb_repeat_ctrl with short tick/debounce/hold/repeat constants.
module tb_pb_repeat_ctrl;

    localparam int TICK_DIV = 9;
    localparam int DEB_MS   = 3;
    localparam int HOLD_MS  = 5;
    localparam int RPT_MS   = 2;
    localparam int TICK_CYC = TICK_DIV + 1;
    // Press/release to pressed change: 2 sync edges, 0..9 cycles to first tick, 2 more ticks, 1 edge.
    localparam int LAT_MIN  = 2 + (DEB_MS - 1) * TICK_CYC + 1;
    localparam int LAT_MAX  = LAT_MIN + TICK_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] push_but = 3'b111;
    logic       man_sw = 1'b0;
    logic [2:0] pben;
    logic [2:0] pressed;

    int n_chk = 0;
    int n_fail = 0;

    pb_repeat_ctrl #(
        .TICK_DIV(TICK_DIV),
        .DEB_MS  (DEB_MS),
        .HOLD_MS (HOLD_MS),
        .RPT_MS  (RPT_MS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .push_but(push_but),
        .man_sw  (man_sw),
        .pben    (pben),
        .pressed (pressed)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pq0[$];
    int pq1[$];
    int pq2[$];
    int rise_cyc [3] = '{0, 0, 0};
    int fall_cyc [3] = '{0, 0, 0};
    int n_rise   [3] = '{0, 0, 0};
    logic [2:0] prev_pressed = 3'b000;

    always @(negedge clk) begin
        if (pben[0]) pq0.push_back(cyc);
        if (pben[1]) pq1.push_back(cyc);
        if (pben[2]) pq2.push_back(cyc);
        for (int b = 0; b < 3; b++) begin
            if (pressed[b] && !prev_pressed[b]) begin
                rise_cyc[b] <= cyc;
                n_rise[b]   <= n_rise[b] + 1;
            end
            if (!pressed[b] && prev_pressed[b]) begin
                fall_cyc[b] <= cyc;
            end
        end
        prev_pressed <= pressed;
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int pget(input int b, input int i);
        case (b)
            0: return (i >= 0 && i < pq0.size()) ? pq0[i] : -1000;
            1: return (i >= 0 && i < pq1.size()) ? pq1[i] : -1000;
            default: return (i >= 0 && i < pq2.size()) ? pq2[i] : -1000;
        endcase
    endfunction

    initial begin
        int t;
        int lat;
        int bad;
        int b0;
        int b1;
        int b2;
        int r0;
        int r1;
        int r2;
        int rel_cyc;

        wait_cyc(5);
        chk("reset_pben", int'(pben), 0);
        chk("reset_pressed", int'(pressed), 0);
        rst = 1'b0;
        man_sw = 1'b1;
        wait_cyc(95);

        // Button 0: press, hold through auto-repeat, release.
        b0 = pq0.size();
        r0 = n_rise[0];
        t = cyc;
        push_but[0] = 1'b0;
        wait_cyc(200);
        chk("b0_rise_count", n_rise[0] - r0, 1);
        lat = rise_cyc[0] - t;
        chk("b0_press_latency_in_window", int'(lat >= LAT_MIN && lat <= LAT_MAX), 1);
        chk("b0_pulse_count_ge4", int'(pq0.size() - b0 >= 4), 1);
        chk("b0_first_pulse", pget(0, b0), rise_cyc[0] + 1);
        chk("b0_hold_gap", pget(0, b0 + 1) - pget(0, b0), HOLD_MS * TICK_CYC - 1);
        bad = 0;
        for (int i = b0 + 2; i < pq0.size(); i++) begin
            if (pq0[i] - pq0[i-1] != RPT_MS * TICK_CYC) bad++;
        end
        chk("b0_repeat_gaps", bad, 0);
        rel_cyc = cyc;
        push_but[0] = 1'b1;
        wait_cyc(60);
        lat = fall_cyc[0] - rel_cyc;
        chk("b0_release_latency_in_window", int'(lat >= LAT_MIN && lat <= LAT_MAX), 1);
        bad = 0;
        for (int i = b0; i < pq0.size(); i++) begin
            if (pq0[i] >= fall_cyc[0]) bad++;
        end
        chk("b0_no_pulse_after_release", bad, 0);

        // Button 1: 15-cycle glitch must be rejected.
        b1 = pq1.size();
        r1 = n_rise[1];
        push_but[1] = 1'b0;
        wait_cyc(15);
        push_but[1] = 1'b1;
        wait_cyc(60);
        chk("b1_glitch_no_rise", n_rise[1] - r1, 0);
        chk("b1_glitch_no_pulse", pq1.size() - b1, 0);
        chk("b1_glitch_pressed", int'(pressed[1]), 0);

        // Button 2: pressed while disabled, enable while held, then re-press.
        b2 = pq2.size();
        man_sw = 1'b0;
        push_but[2] = 1'b0;
        wait_cyc(50);
        chk("b2_lock_pressed", int'(pressed[2]), 1);
        man_sw = 1'b1;
        wait_cyc(60);
        chk("b2_lock_no_pulse", pq2.size() - b2, 0);
        push_but[2] = 1'b1;
        wait_cyc(50);
        chk("b2_lock_released", int'(pressed[2]), 0);
        b2 = pq2.size();
        push_but[2] = 1'b0;
        wait_cyc(36);
        push_but[2] = 1'b1;
        wait_cyc(50);
        chk("b2_repress_one_pulse", pq2.size() - b2, 1);
        chk("b2_repress_pulse_time", pget(2, b2), rise_cyc[2] + 1);

        // Buttons 0 and 2 together.
        b0 = pq0.size();
        b1 = pq1.size();
        b2 = pq2.size();
        push_but = 3'b010;
        wait_cyc(36);
        chk("dual_b0_count", pq0.size() - b0, 1);
        chk("dual_b2_count", pq2.size() - b2, 1);
        chk("dual_b1_count", pq1.size() - b1, 0);
        chk("dual_same_cycle", pget(2, b2), pget(0, b0));
        push_but = 3'b111;
        wait_cyc(50);

        // Button 1 reset during auto-repeat while still held.
        b1 = pq1.size();
        push_but[1] = 1'b0;
        wait_cyc(100);
        chk("b1_repeating_before_rst", int'(pq1.size() - b1 >= 2), 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_pben", int'(pben), 0);
        chk("rst_mid_pressed", int'(pressed), 0);
        wait_cyc(3);
        chk("rst_hold_pben", int'(pben), 0);
        rst = 1'b0;
        t = cyc;
        b1 = pq1.size();
        r1 = n_rise[1];
        wait_cyc(40);
        chk("b1_after_rst_rise_count", n_rise[1] - r1, 1);
        chk("b1_after_rst_rise_time", rise_cyc[1], t + TICK_DIV + (DEB_MS - 1) * TICK_CYC + 1);
        chk("b1_after_rst_pulse_count", pq1.size() - b1, 1);
        chk("b1_after_rst_pulse_time", pget(1, b1), rise_cyc[1] + 1);
        r2 = 0;
        r0 = 0;
        push_but[1] = 1'b1;
        wait_cyc(50);
        chk("final_pressed_clear", int'(pressed), r0 + r2);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
